// File: rtl/pll_dyn_cfg_seq.sv
// PLL dynamic reconfiguration sequencer: power-down/reset/lock bring-up with lock
// filtering, timeout retries, and divider/duty updates applied through a PLL reset.
module pll_dyn_cfg_seq #(
  parameter int unsigned PWD_CYCLES   = 10,
  parameter int unsigned RST_CYCLES   = 10,
  parameter int unsigned LOCK_FILTER  = 3,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DEF_ODIV     = 100,
  parameter int unsigned DEF_DUTY     = 100
) (
  input  logic        clk_tb,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic        cfg_req,
  input  logic [9:0]  cfg_odiv,
  input  logic [9:0]  cfg_duty,
  output logic        cfg_ack,
  output logic        cfg_nak,
  output logic        pll_pwd,
  output logic        pll_rst,
  output logic [9:0]  dyn_odiv0,
  output logic [9:0]  dyn_duty0,
  output logic        ready,
  output logic        fail,
  output logic [2:0]  err_cnt
);

  localparam int unsigned DW        = 10;
  localparam int unsigned CNT_MAX_A = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);
  localparam int unsigned FW        = $clog2(LOCK_FILTER + 1);
  localparam int unsigned RW        = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_PWRDN, S_RST, S_WAIT_LOCK, S_RUN, S_APPLY, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   flt_q, flt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [RW:0]     retry_inc;
  logic [1:0]      hold_q, hold_d;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic [DW-1:0]   lat_odiv_q, lat_odiv_d, lat_duty_q, lat_duty_d;
  logic [DW-1:0]   odiv_d, duty_d;
  logic [2:0]      err_d;
  logic            pwd_d, rst_d, ready_d, fail_d, ack_d, nak_d;
  logic            timeout, lost, accept, reject, fail_clr;
  logic            cfg_valid, cfg_eval;

  assign lock_s    = sync_q[1];
  assign retry_inc = {1'b0, retry_q} + (RW+1)'(1);
  // Holdoff keeps a still-high request from being re-judged right after ack/nak.
  assign cfg_eval  = cfg_req && (hold_q == 2'd0);
  assign cfg_valid = (cfg_odiv != '0) && (cfg_duty != '0) &&
                     ({1'b0, cfg_duty} <= {cfg_odiv, 1'b0});

  // State and datapath registers
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PWRDN;
      cnt_q      <= '0;
      flt_q      <= '0;
      retry_q    <= '0;
      hold_q     <= 2'd0;
      sync_q     <= 2'b00;
      lat_odiv_q <= DW'(DEF_ODIV);
      lat_duty_q <= DW'(DEF_DUTY);
      dyn_odiv0  <= DW'(DEF_ODIV);
      dyn_duty0  <= DW'(DEF_DUTY);
      pll_pwd    <= 1'b1;
      pll_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      cfg_ack    <= 1'b0;
      cfg_nak    <= 1'b0;
      err_cnt    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flt_q      <= flt_d;
      retry_q    <= retry_d;
      hold_q     <= hold_d;
      sync_q     <= {sync_q[0], pll_lock};
      lat_odiv_q <= lat_odiv_d;
      lat_duty_q <= lat_duty_d;
      dyn_odiv0  <= odiv_d;
      dyn_duty0  <= duty_d;
      pll_pwd    <= pwd_d;
      pll_rst    <= rst_d;
      ready      <= ready_d;
      fail       <= fail_d;
      cfg_ack    <= ack_d;
      cfg_nak    <= nak_d;
      err_cnt    <= err_d;
    end
  end

  // Next-state decode; lock loss outranks a request in RUN
  always_comb begin
    state_d  = state_q;
    timeout  = 1'b0;
    lost     = 1'b0;
    accept   = 1'b0;
    reject   = 1'b0;
    fail_clr = 1'b0;
    case (state_q)
      S_PWRDN: if (cnt_q == CW'(PWD_CYCLES - 1)) state_d = S_RST;
      S_RST:   if (cnt_q == CW'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s && (flt_q == FW'(LOCK_FILTER - 1))) begin
          state_d = S_RUN;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = (retry_inc < (RW+1)'(MAX_RETRY)) ? S_PWRDN : S_FAIL;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost    = 1'b1;
          state_d = S_RST;
        end else if (cfg_eval) begin
          if (cfg_valid) begin
            accept  = 1'b1;
            state_d = S_APPLY;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      S_APPLY: state_d = S_RST;
      S_FAIL: begin
        if (cfg_eval) begin
          fail_clr = 1'b1;
          state_d  = S_PWRDN;
        end
      end
      default: state_d = S_PWRDN;
    endcase
  end

  // Output and datapath next values; outputs are decoded from the next state
  always_comb begin
    pwd_d   = 1'b0;
    rst_d   = 1'b0;
    ready_d = 1'b0;
    fail_d  = 1'b0;
    ack_d   = accept || fail_clr;
    nak_d   = reject;
    case (state_d)
      S_PWRDN: begin pwd_d = 1'b1; rst_d = 1'b1; end
      S_RST:   rst_d = 1'b1;
      S_RUN:   ready_d = 1'b1;
      S_APPLY: rst_d = 1'b1;
      S_FAIL:  begin pwd_d = 1'b1; rst_d = 1'b1; fail_d = 1'b1; end
      default: ;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_PWRDN || state_q == S_RST || state_q == S_WAIT_LOCK) begin
      cnt_d = cnt_q + CW'(1);
    end

    flt_d = '0;
    if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s) flt_d = flt_q + FW'(1);

    retry_d = retry_q;
    if (timeout) retry_d = retry_inc[RW-1:0];
    else if (state_q == S_RUN || fail_clr) retry_d = '0;

    err_d = err_cnt;
    if ((timeout || lost) && err_cnt != 3'd7) err_d = err_cnt + 3'd1;

    hold_d = 2'd0;
    if (accept || reject || fail_clr) hold_d = 2'd2;
    else if (hold_q != 2'd0) hold_d = hold_q - 2'd1;

    lat_odiv_d = accept ? cfg_odiv : lat_odiv_q;
    lat_duty_d = accept ? cfg_duty : lat_duty_q;
    odiv_d     = (state_q == S_APPLY) ? lat_odiv_q : dyn_odiv0;
    duty_d     = (state_q == S_APPLY) ? lat_duty_q : dyn_duty0;
  end

endmodule

// File: tb/tb_pll_dyn_cfg_seq.sv
// Bench for pll_dyn_cfg_seq: phase-level reference model checked every cycle,
// directed bring-up/config/timeout/reset scenarios plus randomized requests and lock glitches.
module tb_pll_dyn_cfg_seq;

  localparam int PWD = 10;
  localparam int RSTC = 10;
  localparam int LF = 3;
  localparam int LT = 100;
  localparam int MR = 3;
  localparam int DO = 100;
  localparam int DD = 100;

  logic       clk_tb = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       cfg_req = 1'b0;
  logic [9:0] cfg_odiv = '0;
  logic [9:0] cfg_duty = '0;
  logic       cfg_ack, cfg_nak, pll_pwd, pll_rst, ready, fail;
  logic [9:0] dyn_odiv0, dyn_duty0;
  logic [2:0] err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk_tb = ~clk_tb;

  pll_dyn_cfg_seq #(
    .PWD_CYCLES(PWD), .RST_CYCLES(RSTC), .LOCK_FILTER(LF), .LOCK_TIMEOUT(LT),
    .MAX_RETRY(MR), .DEF_ODIV(DO), .DEF_DUTY(DD)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_req(cfg_req),
    .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty), .cfg_ack(cfg_ack), .cfg_nak(cfg_nak),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .dyn_odiv0(dyn_odiv0), .dyn_duty0(dyn_duty0),
    .ready(ready), .fail(fail), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: phase + remaining-cycle countdowns
  typedef enum int {M_PWRDN, M_RST, M_WAIT, M_RUN, M_APPLY, M_FAIL} mph_t;
  mph_t m_ph;
  int   m_left, m_waited, m_streak, m_retries, m_err, m_hold;
  int   m_odiv, m_duty, m_pend_odiv, m_pend_duty;
  bit   m_s0, m_s1, m_ack, m_nak;

  function automatic void m_enter(input mph_t p);
    m_ph = p;
    if (p == M_PWRDN) m_left = PWD;
    if (p == M_RST) m_left = RSTC;
    if (p == M_WAIT) begin m_waited = 0; m_streak = 0; end
  endfunction

  function automatic void m_reset();
    m_enter(M_PWRDN);
    m_retries = 0; m_err = 0; m_hold = 0;
    m_s0 = 1'b0; m_s1 = 1'b0; m_ack = 1'b0; m_nak = 1'b0;
    m_odiv = DO; m_duty = DD; m_pend_odiv = DO; m_pend_duty = DD;
  endfunction

  function automatic void m_step();
    bit ls;
    bit gate;
    bit ok;
    ls = m_s1;
    gate = (m_hold == 0);
    m_s1 = m_s0;
    m_s0 = pll_lock;
    m_ack = 1'b0;
    m_nak = 1'b0;
    if (m_hold > 0) m_hold--;
    ok = (cfg_odiv != 0) && (cfg_duty != 0) && (int'(cfg_duty) <= 2 * int'(cfg_odiv));
    case (m_ph)
      M_PWRDN: begin m_left--; if (m_left == 0) m_enter(M_RST); end
      M_RST:   begin m_left--; if (m_left == 0) m_enter(M_WAIT); end
      M_WAIT: begin
        m_streak = ls ? m_streak + 1 : 0;
        m_waited++;
        if (m_streak == LF) m_enter(M_RUN);
        else if (m_waited == LT) begin
          if (m_err < 7) m_err++;
          m_retries++;
          if (m_retries < MR) m_enter(M_PWRDN);
          else m_enter(M_FAIL);
        end
      end
      M_RUN: begin
        m_retries = 0;
        if (!ls) begin
          if (m_err < 7) m_err++;
          m_enter(M_RST);
        end else if (cfg_req && gate) begin
          m_hold = 2;
          if (ok) begin
            m_ack = 1'b1;
            m_pend_odiv = int'(cfg_odiv);
            m_pend_duty = int'(cfg_duty);
            m_enter(M_APPLY);
          end else begin
            m_nak = 1'b1;
          end
        end
      end
      M_APPLY: begin m_odiv = m_pend_odiv; m_duty = m_pend_duty; m_enter(M_RST); end
      M_FAIL: begin
        if (cfg_req && gate) begin
          m_ack = 1'b1; m_hold = 2; m_retries = 0;
          m_enter(M_PWRDN);
        end
      end
      default: m_enter(M_PWRDN);
    endcase
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_tb or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_tb);
      chk("cfg_ack", int'(cfg_ack), int'(m_ack));
      chk("cfg_nak", int'(cfg_nak), int'(m_nak));
      chk("pll_pwd", int'(pll_pwd), int'(m_ph == M_PWRDN || m_ph == M_FAIL));
      chk("pll_rst", int'(pll_rst), int'(m_ph != M_WAIT && m_ph != M_RUN));
      chk("ready", int'(ready), int'(m_ph == M_RUN));
      chk("fail", int'(fail), int'(m_ph == M_FAIL));
      chk("err_cnt", int'(err_cnt), m_err);
      chk("dyn_odiv0", int'(dyn_odiv0), m_odiv);
      chk("dyn_duty0", int'(dyn_duty0), m_duty);
    end
  end

  task automatic tick();
    @(negedge clk_tb);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit lvl, input int limit, input string name);
    int n;
    n = 0;
    while (ready != lvl && n < limit) begin tick(); n++; end
    chk(name, int'(ready), int'(lvl));
  endtask

  task automatic do_req(input int o, input int d, output int lat);
    cfg_odiv = 10'(o);
    cfg_duty = 10'(d);
    cfg_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (cfg_ack || cfg_nak) begin lat = i; break; end
    end
    cfg_req = 1'b0;
  endtask

  task automatic pick_cfg(output int o, output int d);
    int mode;
    mode = int'($urandom_range(0, 5));
    case (mode)
      0: begin o = int'($urandom_range(1, 511)); d = int'($urandom_range(1, 2 * o)); end
      1: begin o = 0; d = int'($urandom_range(0, 1023)); end
      2: begin o = int'($urandom_range(1, 1023)); d = 0; end
      3: begin o = int'($urandom_range(1, 400)); d = 2 * o; end
      4: begin o = int'($urandom_range(1, 400)); d = 2 * o + 1; end
      default: begin o = int'($urandom_range(0, 1023)); d = int'($urandom_range(0, 1023)); end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, o, d, age;
    bit act;
    #1;
    // Bring-up with lock constantly high
    pll_lock = 1'b1;
    do_reset();
    n = 0;
    while (n < 100) begin tick(); n++; if (!pll_pwd) break; end
    chk("pwd_len", n, 10);
    while (n < 100) begin if (!pll_rst) break; tick(); n++; end
    chk("rst_fall", n, 20);
    while (n < 100) begin if (ready) break; tick(); n++; end
    chk("ready_at", n, 23);
    chk("bringup_odiv", int'(dyn_odiv0), 100);
    chk("model_odiv_pin", m_odiv, 100);

    // Valid update 200/200
    do_req(200, 200, lat);
    chk("upd_lat", lat, 1);
    chk("upd_ack", int'(cfg_ack), 1);
    chk("upd_ready_apply", int'(ready), 0);
    n = 0;
    while (pll_rst && n < 50) begin n++; tick(); end
    chk("upd_rst_len", n, 11);
    wait_ready(1'b1, 40, "upd_relock");
    chk("upd_odiv", int'(dyn_odiv0), 200);
    chk("upd_duty", int'(dyn_duty0), 200);
    chk("model_odiv_after", m_odiv, 200);

    // Rejects and the duty == 2*odiv boundary
    do_req(0, 5, lat);
    chk("nak0_lat", lat, 1);
    chk("nak0", int'(cfg_nak), 1);
    chk("nak0_ready", int'(ready), 1);
    tick(); tick();
    do_req(50, 101, lat);
    chk("nak_duty_lat", lat, 1);
    chk("nak_duty", int'(cfg_nak), 1);
    tick(); tick();
    chk("nak_keep_odiv", int'(dyn_odiv0), 200);
    chk("nak_keep_ready", int'(ready), 1);
    do_req(50, 100, lat);
    chk("edge_ack", int'(cfg_ack), 1);
    wait_ready(1'b1, 40, "edge_relock");
    chk("edge_odiv", int'(dyn_odiv0), 50);
    chk("edge_duty", int'(dyn_duty0), 100);

    // Lock glitch coincident with a valid request
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    do_req(300, 77, lat);
    chk("loss_req_lat", lat, 15);
    chk("loss_req_ack", int'(cfg_ack), 1);
    chk("loss_err", int'(err_cnt), 1);
    wait_ready(1'b1, 40, "loss_relock");
    chk("loss_odiv", int'(dyn_odiv0), 300);

    // Randomized requests, lock glitches and occasional resets
    act = 1'b0;
    age = 0;
    for (int c = 0; c < 3000; c++) begin
      if (act) begin
        if (cfg_ack || cfg_nak) begin
          cfg_req = 1'b0; act = 1'b0;
        end else begin
          age++;
          if (age > 400) begin chk("rnd_req_bound", 0, 1); cfg_req = 1'b0; act = 1'b0; end
        end
      end else if ($urandom_range(0, 99) < 12) begin
        pick_cfg(o, d);
        cfg_odiv = 10'(o); cfg_duty = 10'(d); cfg_req = 1'b1;
        act = 1'b1; age = 0;
      end
      pll_lock = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 999) < 2) begin
        rst_n = 1'b0; cfg_req = 1'b0; act = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    cfg_req = 1'b0;

    // Lock never arrives: three attempts then FAIL
    pll_lock = 1'b0;
    do_reset();
    n = 0;
    while (n < 1000) begin tick(); n++; if (fail) break; end
    chk("fail_at", n, 360);
    chk("fail_err", int'(err_cnt), 3);
    chk("fail_pwd", int'(pll_pwd), 1);
    chk("model_err_pin", m_err, 3);
    pll_lock = 1'b1;
    do_req(5, 900, lat);
    chk("fail_clr_lat", lat, 1);
    chk("fail_clr_ack", int'(cfg_ack), 1);
    chk("fail_clr_fail", int'(fail), 0);
    chk("fail_clr_pwd", int'(pll_pwd), 1);
    wait_ready(1'b1, 60, "fail_relock");
    chk("fail_odiv_kept", int'(dyn_odiv0), 100);
    chk("fail_err_kept", int'(err_cnt), 3);

    // Saturation of the error counter
    for (int k = 0; k < 6; k++) begin
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      wait_ready(1'b0, 10, "sat_drop");
      wait_ready(1'b1, 60, "sat_relock");
    end
    chk("err_sat", int'(err_cnt), 7);

    // Reset in the middle of APPLY
    do_req(200, 200, lat);
    chk("rstapply_ack", int'(cfg_ack), 1);
    chk("rstapply_in_apply", int'(pll_rst && !ready), 1);
    rst_n = 1'b0;
    #1;
    chk("rstapply_odiv", int'(dyn_odiv0), 100);
    chk("rstapply_duty", int'(dyn_duty0), 100);
    chk("rstapply_pwd", int'(pll_pwd), 1);
    chk("rstapply_ack0", int'(cfg_ack), 0);
    chk("rstapply_err0", int'(err_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    while (n < 100) begin tick(); n++; if (!pll_pwd) break; end
    chk("rstapply_pwd_len", n, 10);
    wait_ready(1'b1, 60, "rstapply_relock");
    chk("rstapply_odiv_end", int'(dyn_odiv0), 100);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
